hack_mux4_way_arb: RTL and testbench
====================================

Name: hack_mux4_way_arb

Overview:
- Sequential 4-to-1 merge. It is the converging counterpart of the 4-way demux.
- Four independent valid/ready source channels (a, b, c, d) are arbitrated round-robin onto one registered output channel.
- The output carries a 2-bit source tag. The tag uses the same sel encoding as the demux, so the two blocks can be paired across a shared link.
- Used wherever several Hack-side producers share one consumer path.

Parameters:
- WIDTH, 16, data width of every input channel and of the output channel.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a_data, b_data, c_data, d_data  input  WIDTH each  source channel data.
- a_valid, b_valid, c_valid, d_valid  input  1 each  source has a word.
- a_ready, b_ready, c_ready, d_ready  output  1 each  word is accepted this cycle.
- out_data  output  WIDTH  registered merged data.
- out_sel  output  2  source tag: 0=a, 1=b, 2=c, 3=d.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word this cycle.

Behaviour:
- Reset (clk edge with reset=1):
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0 (channel a has first priority).
  - Any held word is discarded. Reset overrides every transfer in that cycle.
- Input transfer on a channel x: x_valid && x_ready at a rising edge.
- Output transfer: out_valid && out_ready at a rising edge.
- Sources must hold valid and data stable until their transfer. The block does not check this.
- load_ok = !out_valid || out_ready (combinational). The output register is empty or being drained this cycle.
- Grant (combinational):
  - Scan channels in order rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3, all mod 4.
  - The first channel with valid=1 is granted.
- Ready generation:
  - x_ready = load_ok && (grant==x) && x_valid.
  - At most one ready is high in any cycle.
  - All readies are 0 while reset=1.
- On an input transfer from channel g:
  - out_data<=g_data, out_sel<=g, out_valid<=1.
  - rr_ptr<=(g+1) mod 4; 2-bit wrap, so 3 wraps to 0.
- Output transfer with no input transfer in the same cycle: out_valid<=0. out_data and out_sel hold their last values.
- Simultaneous output transfer and input transfer: the register reloads with the new word and out_valid stays 1. Sustained throughput is one word per clock.
- out_valid=1 with out_ready=0: all readies are 0. The register and rr_ptr hold.
- No valid inputs: rr_ptr holds and no transfer occurs.
- Latency: exactly 1 clock from input transfer edge to out_valid/out_data visible.
- Fairness: a continuously valid channel waits at most 3 output transfers for its grant.
- Combinational paths:
  - x_valid/out_ready to x_ready only.
  - No combinational path from any input to out_data, out_sel or out_valid.

Optional Feature:
- Macro HACK_MUX4_ARB_CNT_EN.
- Defined:
  - Adds output ports cnt_a, cnt_b, cnt_c, cnt_d (8 bits each).
  - Each counter increments by 1 on every input transfer from its channel.
  - Counters saturate at 255 and never wrap.
  - Reset clears all counters to 0.
  - Adds input cnt_clr (1 bit): synchronous clear of all counters. cnt_clr wins over a same-cycle increment.
- Undefined: counter ports and cnt_clr are absent, and no counter logic is generated. All other behaviour is identical.

Test Plan:
- Reset state: drive reset=1 for 2 clocks with all valids=1, out_ready=1 -> all readies 0 during reset; after reset out_valid=0, out_sel=0, out_data=0.
- Single source with 1-clock latency: only c_valid=1, c_data=16'h1234, out_ready=1 -> c_ready=1 at the edge; next cycle out_valid=1, out_data=16'h1234, out_sel=2.
- Round-robin fairness: all four valid continuously, data = 16'h000A/B/C/D, out_ready=1 -> out_sel sequence 0,1,2,3,0,1,... with one word per clock and no gaps.
- Backpressure: load a word, then hold out_ready=0 for 5 clocks with a_valid=b_valid=1 -> all readies 0 and out_data/out_sel stable; on release, the next grant follows rr_ptr.
- Wrap and skip: rr_ptr=3 with only a_valid and b_valid asserted -> grant a (sel 0), then b, confirming the 3->0 wrap and skipping of idle channels.
- Optional counters (HACK_MUX4_ARB_CNT_EN): 300 transfers from d -> cnt_d=255 (saturated), others 0; pulse cnt_clr during a d transfer -> cnt_d=0.

Source files
------------

// File: rtl/hack_mux4_way_arb.sv
// hack_mux4_way_arb
//   Round-robin merge of four valid/ready source channels (a, b, c, d) onto
//   one registered output channel. out_sel tags each word with its source
//   (0=a, 1=b, 2=c, 3=d), using the same encoding as the 4-way demux.
//
// Ports
//   clk, reset                 : clock, synchronous active-high reset
//   {a,b,c,d}_data/_valid      : source channels (inputs)
//   {a,b,c,d}_ready            : source accepted this cycle (outputs)
//   out_data/out_sel/out_valid : registered merged output channel
//   out_ready                  : consumer accepts the output word this cycle
//
// Optional feature (macro HACK_MUX4_ARB_CNT_EN)
//   Adds cnt_clr input and saturating 8-bit per-channel transfer counters
//   cnt_a..cnt_d. Without the macro those ports and the counter logic are
//   absent.

module hack_mux4_way_arb #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic [WIDTH-1:0] c_data,
  input  logic [WIDTH-1:0] d_data,
  input  logic             a_valid,
  input  logic             b_valid,
  input  logic             c_valid,
  input  logic             d_valid,
  output logic             a_ready,
  output logic             b_ready,
  output logic             c_ready,
  output logic             d_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready
`ifdef HACK_MUX4_ARB_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [7:0]       cnt_a,
  output logic [7:0]       cnt_b,
  output logic [7:0]       cnt_c,
  output logic [7:0]       cnt_d
`endif
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;

  logic [3:0]       vld;
  logic [3:0]       rdy;
  logic [1:0]       grant;
  logic [1:0]       scan_idx;
  logic             grant_found;
  logic             load_ok;
  logic             take;
  logic [WIDTH-1:0] grant_data;

  assign vld = {d_valid, c_valid, b_valid, a_valid};

  // First valid channel at or after rr_ptr, wrapping mod 4.
  always_comb begin
    grant_found = 1'b0;
    grant       = rr_ptr_q;
    scan_idx    = rr_ptr_q;
    for (int i = 0; i < 4; i++) begin
      scan_idx = rr_ptr_q + 2'(i);
      if (!grant_found && vld[scan_idx]) begin
        grant_found = 1'b1;
        grant       = scan_idx;
      end
    end
  end

  assign load_ok = !out_valid_q || out_ready;
  // Reset suppresses all readies so no source believes a word was taken.
  assign take    = load_ok && grant_found && !reset;

  always_comb begin
    rdy = 4'b0000;
    if (take) rdy = 4'b0001 << grant;
  end

  assign a_ready = rdy[0];
  assign b_ready = rdy[1];
  assign c_ready = rdy[2];
  assign d_ready = rdy[3];

  always_comb begin
    case (grant)
      2'd0:    grant_data = a_data;
      2'd1:    grant_data = b_data;
      2'd2:    grant_data = c_data;
      default: grant_data = d_data;
    endcase
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (take) begin
      // Covers both an empty register and a same-cycle drain + reload.
      out_data_d  = grant_data;
      out_sel_d   = grant;
      out_valid_d = 1'b1;
      rr_ptr_d    = grant + 2'd1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= 2'd0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

`ifdef HACK_MUX4_ARB_CNT_EN
  logic [3:0][7:0] xfer_cnt_q, xfer_cnt_d;

  // Clear beats a same-cycle increment; counts stick at 255.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (cnt_clr) begin
      xfer_cnt_d = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (rdy[i] && (xfer_cnt_q[i] != 8'hFF)) xfer_cnt_d[i] = xfer_cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) xfer_cnt_q <= '0;
    else       xfer_cnt_q <= xfer_cnt_d;
  end

  assign cnt_a = xfer_cnt_q[0];
  assign cnt_b = xfer_cnt_q[1];
  assign cnt_c = xfer_cnt_q[2];
  assign cnt_d = xfer_cnt_q[3];
`endif

endmodule

// File: tb/tb_hack_mux4_way_arb.sv
module tb_hack_mux4_way_arb;

  logic        clk;
  logic        reset;
  logic [15:0] a_data, b_data, c_data, d_data;
  logic        a_valid, b_valid, c_valid, d_valid;
  logic        a_ready, b_ready, c_ready, d_ready;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
`ifdef HACK_MUX4_ARB_CNT_EN
  logic        cnt_clr;
  logic [7:0]  cnt_a, cnt_b, cnt_c, cnt_d;
`endif

  int errors = 0;
  int checks = 0;

  hack_mux4_way_arb #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_data    (a_data),
    .b_data    (b_data),
    .c_data    (c_data),
    .d_data    (d_data),
    .a_valid   (a_valid),
    .b_valid   (b_valid),
    .c_valid   (c_valid),
    .d_valid   (d_valid),
    .a_ready   (a_ready),
    .b_ready   (b_ready),
    .c_ready   (c_ready),
    .d_ready   (d_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef HACK_MUX4_ARB_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b),
    .cnt_c     (cnt_c),
    .cnt_d     (cnt_d)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;       // {d,c,b,a}
    logic        ordy;
    logic [3:0]  exp_rdy;   // {d,c,b,a}, before the edge
    logic        exp_ov;    // after the edge
    logic [1:0]  exp_sel;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [3:0] vld, input logic ordy, input logic [3:0] rdy,
                         input logic ov, input logic [1:0] sel, input logic [15:0] data);
    vec_t v;
    v.vld = vld; v.ordy = ordy; v.exp_rdy = rdy;
    v.exp_ov = ov; v.exp_sel = sel; v.exp_data = data;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] readies();
    return {d_ready, c_ready, b_ready, a_ready};
  endfunction

  task automatic set_valid(input logic [3:0] v);
    {d_valid, c_valid, b_valid, a_valid} = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    a_data    = 16'h000A;
    b_data    = 16'h000B;
    c_data    = 16'h000C;
    d_data    = 16'h000D;
    out_ready = 1'b1;
    set_valid(4'b1111);
`ifdef HACK_MUX4_ARB_CNT_EN
    cnt_clr   = 1'b0;
`endif

    // Reset with all sources valid: no ready may rise.
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("reset_rdy_%0d", i), 32'(readies()), 32'h0);
      step();
    end
    reset = 1'b0;
    set_valid(4'b0000);
    #1;
    check("reset_ov",   32'(out_valid), 32'h0);
    check("reset_sel",  32'(out_sel),   32'h0);
    check("reset_data", 32'(out_data),  32'h0);

    // Single source c with 1-clock latency.
    c_data = 16'h1234;
    set_valid(4'b0100);
    #1;
    check("single_c_rdy", 32'(readies()), 32'h4);
    check("single_c_ov_before", 32'(out_valid), 32'h0);
    step();
    set_valid(4'b0000);
    check("single_c_ov",   32'(out_valid), 32'h1);
    check("single_c_data", 32'(out_data),  32'h1234);
    check("single_c_sel",  32'(out_sel),   32'h2);
    c_data = 16'h000C;

    // Reset discards a held word and returns rr_ptr to a.
    do_reset();
    check("rst_discard_ov",   32'(out_valid), 32'h0);
    check("rst_discard_data", 32'(out_data),  32'h0);

    // Round robin, back-to-back, no gaps.
    add_vec(4'b1111, 1, 4'b0001, 1, 0, 16'h000A);
    add_vec(4'b1111, 1, 4'b0010, 1, 1, 16'h000B);
    add_vec(4'b1111, 1, 4'b0100, 1, 2, 16'h000C);
    add_vec(4'b1111, 1, 4'b1000, 1, 3, 16'h000D);
    add_vec(4'b1111, 1, 4'b0001, 1, 0, 16'h000A);
    // Backpressure for 5 clocks: register and rr_ptr (=1) hold.
    add_vec(4'b0011, 0, 4'b0000, 1, 0, 16'h000A);
    add_vec(4'b0011, 0, 4'b0000, 1, 0, 16'h000A);
    add_vec(4'b0011, 0, 4'b0000, 1, 0, 16'h000A);
    add_vec(4'b0011, 0, 4'b0000, 1, 0, 16'h000A);
    add_vec(4'b0011, 0, 4'b0000, 1, 0, 16'h000A);
    // Release: rr_ptr=1 so b wins over a, reload while draining.
    add_vec(4'b0011, 1, 4'b0010, 1, 1, 16'h000B);
    // rr_ptr=2, only a valid: skips c, d and wraps to a.
    add_vec(4'b0001, 1, 4'b0001, 1, 0, 16'h000A);
    // Drain with no input: out_valid drops, data/sel hold.
    add_vec(4'b0000, 1, 4'b0000, 0, 0, 16'h000A);
    add_vec(4'b0000, 0, 4'b0000, 0, 0, 16'h000A);
    // Empty register accepts even while out_ready=0.
    add_vec(4'b1000, 0, 4'b1000, 1, 3, 16'h000D);
    add_vec(4'b0000, 1, 4'b0000, 0, 3, 16'h000D);
    // rr_ptr=0, c only -> rr_ptr becomes 3.
    add_vec(4'b0100, 1, 4'b0100, 1, 2, 16'h000C);
    // rr_ptr=3 with a,b: 3->0 wrap grants a, then b.
    add_vec(4'b0011, 1, 4'b0001, 1, 0, 16'h000A);
    add_vec(4'b0011, 1, 4'b0010, 1, 1, 16'h000B);
    add_vec(4'b0000, 1, 4'b0000, 0, 1, 16'h000B);

    foreach (vecs[k]) begin
      set_valid(vecs[k].vld);
      out_ready = vecs[k].ordy;
      #1;
      check($sformatf("vec%0d_rdy", k), 32'(readies()), 32'(vecs[k].exp_rdy));
      step();
      check($sformatf("vec%0d_ov", k),   32'(out_valid), 32'(vecs[k].exp_ov));
      check($sformatf("vec%0d_sel", k),  32'(out_sel),   32'(vecs[k].exp_sel));
      check($sformatf("vec%0d_data", k), 32'(out_data),  32'(vecs[k].exp_data));
    end
    set_valid(4'b0000);

`ifdef HACK_MUX4_ARB_CNT_EN
    do_reset();
    check("cnt_reset_a", 32'(cnt_a), 32'h0);
    out_ready = 1'b1;
    set_valid(4'b1000);
    for (int i = 0; i < 300; i++) step();
    check("cnt_sat_d", 32'(cnt_d), 32'd255);
    check("cnt_sat_a", 32'(cnt_a), 32'd0);
    check("cnt_sat_b", 32'(cnt_b), 32'd0);
    check("cnt_sat_c", 32'(cnt_c), 32'd0);
    cnt_clr = 1'b1;
    #1;
    check("cnt_clr_xfer_rdy", 32'(readies()), 32'h8);
    step();
    cnt_clr = 1'b0;
    check("cnt_clr_d", 32'(cnt_d), 32'd0);
    step();
    check("cnt_after_clr_d", 32'(cnt_d), 32'd1);
    set_valid(4'b0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
